maze_grid_mem: RTL and testbench
================================

Name: maze_grid_mem

Overview:
- Parametrised grid memory holding the maze map, addressed by (x, y) cell coordinates, with multi-bit cells.
- Hardware init engine copies a ROM image into working storage after reset or on request.
- Provides a registered single-cell read and a registered four-neighbour fetch with out-of-bounds cells reported as walls.
- Sits between the maze solver FSM and the map storage.

Parameters:
X_BITS, 4, x coordinate width; grid width GW = 2**X_BITS
Y_BITS, 4, y coordinate width; grid height GH = 2**Y_BITS
CELL_W, 1, bits per cell
INIT_FILE, "Mem.data", hex image loaded into shadow ROM at elaboration, cell order {x,y} linear
OOB_VALUE, all ones (CELL_W bits), value returned for out-of-grid neighbours (wall)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
init_req  in  1  pulse: re-copy ROM image into working memory
busy  out  1  high while init engine runs
x  in  X_BITS  cell x coordinate
y  in  Y_BITS  cell y coordinate
wr  in  1  write enable
wdata  in  CELL_W  write data
rd  in  1  single-cell read request
rdata  out  CELL_W  read data
rvalid  out  1  one-cycle pulse, rdata valid
nbr_rd  in  1  neighbour fetch request at (x, y)
nbr_n, nbr_e, nbr_s, nbr_w  out  CELL_W each  cells (x,y-1), (x+1,y), (x,y+1), (x-1,y)
nbr_valid  out  1  one-cycle pulse, nbr_* valid
access_err  out  1  one-cycle pulse: rd/wr/nbr_rd asserted while busy

Behaviour:
- Storage: DEPTH = GW*GH cells. Linear index = {x,y}. The shadow ROM holds INIT_FILE and is read-only. Working memory contents are undefined until the first init completes.
- Reset (rst high, async):
  - state=INIT, init counter=0, busy=1.
  - rdata=0, rvalid=0, nbr_*=0, nbr_valid=0, access_err=0.
  - Working memory is not cleared by reset.
- FSM states: INIT, IDLE.
  - INIT: each rising edge copies rom[cnt] to mem[cnt] and increments cnt. The edge that copies cnt=DEPTH-1 moves state to IDLE. Busy is therefore high for exactly DEPTH edges after rst deasserts and drops the cycle after the last copy.
  - IDLE: on init_req, cnt=0 and state=INIT next edge. Any rd/wr/nbr_rd on that same edge is still served. init_req during INIT is ignored (no restart).
- Write: in IDLE, wr at the edge sets mem[{x,y}] = wdata. While busy, the write is dropped and access_err pulses.
- Read: in IDLE, rd at edge N gives rdata = mem[{x,y}] and rvalid=1 after edge N. rvalid falls after edge N+1 unless rd is held.
  - Read-first ordering: rd and wr to the same cell on the same edge returns the old value.
  - rdata holds its last value when rvalid=0.
- Neighbour fetch: in IDLE, nbr_rd at edge N registers all four neighbours and pulses nbr_valid after edge N, with the same read-first rule.
  - Bounds: no wrap-around. y=0 gives nbr_n=OOB_VALUE; y=GH-1 gives nbr_s=OOB_VALUE; x=GW-1 gives nbr_e=OOB_VALUE; x=0 gives nbr_w=OOB_VALUE.
  - The centre cell is not returned.
- Simultaneous events: rd and nbr_rd on the same edge are both served, sharing the coordinates. wr with either read is also allowed.
- Error reporting: any rd/wr/nbr_rd while busy is dropped; rvalid and nbr_valid stay 0 and access_err pulses for one cycle.
- Reset mid-init or mid-operation: the init restarts from cnt=0 after rst deasserts. Pending rvalid/nbr_valid are cleared.

Test Plan:
1. Default params, INIT_FILE with cell(3,5)=1 and all others 0. Release rst; hold rd at (3,5) from the start. Expect busy=1 for exactly 256 edges and access_err each busy cycle. After busy falls: rdata=1, rvalid=1, one cycle later.
2. In IDLE, on the same edge: wr (7,7) wdata=1 and rd (7,7) with old value 0 → rdata=0. The next read of (7,7) → rdata=1.
3. nbr_rd at (0,0), cells (1,0)=1 and (0,1)=0 → nbr_n=1 (OOB), nbr_w=1 (OOB), nbr_e=1, nbr_s=0, nbr_valid one pulse. nbr_rd at (15,15) → nbr_s=1, nbr_e=1 (OOB).
4. Write (2,2)=1, then init_req with ROM (2,2)=0. Expect busy for 256 cycles; init_req during busy does not extend it. Afterwards rd (2,2) → 0.
5. Assert rst at init cycle 100 for 3 cycles. Expect outputs 0 and busy=1 immediately (async). Busy stays high for a full 256 edges after release; image correct afterwards.
6. X_BITS=3, Y_BITS=2, CELL_W=4, OOB_VALUE=4'hF. Expect busy for 32 edges. nbr_rd at (7,3) → nbr_e=4'hF, nbr_s=4'hF, nbr_n and nbr_w from ROM.

Source files
------------

// File: rtl/maze_grid_mem_if.sv
// Solver-to-map bus: coordinates, read/write/neighbour requests and their results.
// Latency: none (wires only).
// Backpressure: none; the map reports busy and flags any request made while busy.
interface maze_grid_mem_if #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4,
  parameter int CELL_W = 1
);
  logic              init_req;
  logic              busy;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic              wr;
  logic [CELL_W-1:0] wdata;
  logic              rd;
  logic [CELL_W-1:0] rdata;
  logic              rvalid;
  logic              nbr_rd;
  logic [CELL_W-1:0] nbr_n;
  logic [CELL_W-1:0] nbr_e;
  logic [CELL_W-1:0] nbr_s;
  logic [CELL_W-1:0] nbr_w;
  logic              nbr_valid;
  logic              access_err;

  // Solver side: issues requests, consumes results.
  modport master (
    output init_req, x, y, wr, wdata, rd, nbr_rd,
    input  busy, rdata, rvalid, nbr_n, nbr_e, nbr_s, nbr_w, nbr_valid, access_err
  );

  // Map side: serves requests.
  modport slave (
    input  init_req, x, y, wr, wdata, rd, nbr_rd,
    output busy, rdata, rvalid, nbr_n, nbr_e, nbr_s, nbr_w, nbr_valid, access_err
  );
endinterface

// File: rtl/maze_grid_mem.sv
// Maze map storage: (x,y)-addressed cells, ROM-image init engine, single-cell read and 4-neighbour fetch.
// Latency: reads/neighbour fetches are registered, valid one edge after the request; init takes DEPTH edges.
// Backpressure: none; requests while busy are dropped and access_err pulses for one cycle.
module maze_grid_mem #(
  parameter int                              X_BITS    = 4,
  parameter int                              Y_BITS    = 4,
  parameter int                              CELL_W    = 1,
  parameter string                           INIT_FILE = "Mem.data",
  parameter logic [CELL_W-1:0]               OOB_VALUE = '1,
  // Inline ROM image (cell i at bits [i*CELL_W +: CELL_W]).
  parameter logic [(2**(X_BITS+Y_BITS))*CELL_W-1:0] ROM_INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  maze_grid_mem_if.slave  bus
);

  localparam int GW     = 2**X_BITS;
  localparam int GH     = 2**Y_BITS;
  localparam int DEPTH  = GW*GH;
  localparam int ADDR_W = X_BITS + Y_BITS;

  localparam logic [X_BITS-1:0] X_ONE  = 1;
  localparam logic [Y_BITS-1:0] Y_ONE  = 1;
  localparam logic [X_BITS-1:0] X_MAX  = '1;
  localparam logic [Y_BITS-1:0] Y_MAX  = '1;
  localparam logic [ADDR_W-1:0] A_ONE  = 1;
  localparam logic [ADDR_W-1:0] A_MAX  = '1;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  // Working memory: never reset, filled by the init engine.
  logic [CELL_W-1:0] r_mem [DEPTH];

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [CELL_W-1:0] w_mem_dat;
  logic [CELL_W-1:0] w_rom_dat;

  logic              w_busy;
  logic              w_idle;
  logic [ADDR_W-1:0] w_idx;
  logic [CELL_W-1:0] w_n;
  logic [CELL_W-1:0] w_e;
  logic [CELL_W-1:0] w_s;
  logic [CELL_W-1:0] w_w;

  logic              r_rvalid;
  logic [CELL_W-1:0] r_rdata;
  logic              r_nbr_valid;
  logic [CELL_W-1:0] r_nbr_n;
  logic [CELL_W-1:0] r_nbr_e;
  logic [CELL_W-1:0] r_nbr_s;
  logic [CELL_W-1:0] r_nbr_w;
  logic              r_err;

  // Shadow ROM: read-only inline image.
  assign w_rom_dat = ROM_INIT[int'(r_cnt)*CELL_W +: CELL_W];

  assign w_busy = (r_state == S_INIT);
  assign w_idle = (r_state == S_IDLE);
  assign w_idx  = {bus.x, bus.y};

  // Neighbours never wrap: any step off the grid reads as a wall.
  assign w_n = (bus.y == '0)   ? OOB_VALUE : r_mem[{bus.x, bus.y - Y_ONE}];
  assign w_s = (bus.y == Y_MAX) ? OOB_VALUE : r_mem[{bus.x, bus.y + Y_ONE}];
  assign w_e = (bus.x == X_MAX) ? OOB_VALUE : r_mem[{bus.x + X_ONE, bus.y}];
  assign w_w = (bus.x == '0)   ? OOB_VALUE : r_mem[{bus.x - X_ONE, bus.y}];

  // State register: reset restarts the init copy from cell 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and memory write port: init copy owns the port while busy, solver writes otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_addr  = w_idx;
    w_mem_dat   = bus.wdata;
    case (r_state)
      S_INIT: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_dat  = w_rom_dat;
        w_cnt_nxt  = r_cnt + A_ONE;
        if (r_cnt == A_MAX) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_mem_we = bus.wr;
        // Requests on the init_req edge are still served; the copy starts on the next edge.
        if (bus.init_req) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Single write port; reads elsewhere see the pre-edge contents (read-first).
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_addr] <= w_mem_dat;
    end
  end

  // Registered read, neighbour fetch and error pulse; data regs hold when not refreshed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_nbr_valid <= 1'b0;
      r_nbr_n     <= '0;
      r_nbr_e     <= '0;
      r_nbr_s     <= '0;
      r_nbr_w     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rvalid    <= w_idle & bus.rd;
      r_nbr_valid <= w_idle & bus.nbr_rd;
      r_err       <= w_busy & (bus.rd | bus.wr | bus.nbr_rd);
      if (w_idle && bus.rd) begin
        r_rdata <= r_mem[w_idx];
      end
      if (w_idle && bus.nbr_rd) begin
        r_nbr_n <= w_n;
        r_nbr_e <= w_e;
        r_nbr_s <= w_s;
        r_nbr_w <= w_w;
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.rdata      = r_rdata;
  assign bus.rvalid     = r_rvalid;
  assign bus.nbr_n      = r_nbr_n;
  assign bus.nbr_e      = r_nbr_e;
  assign bus.nbr_s      = r_nbr_s;
  assign bus.nbr_w      = r_nbr_w;
  assign bus.nbr_valid  = r_nbr_valid;
  assign bus.access_err = r_err;

endmodule

// File: tb/tb_maze_grid_mem.sv
// Bench for maze_grid_mem: model-checked 16x16x1 map plus directed checks on an 8x4x4 map.
// Latency: expects registered results one edge after each request, DEPTH edges of init.
// Backpressure: expects requests made while busy to be dropped with an access_err pulse.
module tb_maze_grid_mem;

  localparam int AGW = 16;
  localparam int AGH = 16;
  localparam int AD  = 256;
  // Map A: cells (3,5), (1,0) and (15,14) are walls.
  localparam logic [255:0] ROM_A = (256'h1 << 53) | (256'h1 << 16) | (256'h1 << 254);
  // Map B: cell (7,2)=5 (index 30), cell (6,3)=A (index 27).
  localparam logic [127:0] ROM_B = (128'h5 << 120) | (128'hA << 108);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_grid_mem_if #(.X_BITS(4), .Y_BITS(4), .CELL_W(1)) ifa ();
  maze_grid_mem_if #(.X_BITS(3), .Y_BITS(2), .CELL_W(4)) ifb ();

  maze_grid_mem #(.X_BITS(4), .Y_BITS(4), .CELL_W(1), .INIT_FILE(""),
                  .OOB_VALUE(1'b1), .ROM_INIT(ROM_A))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));

  maze_grid_mem #(.X_BITS(3), .Y_BITS(2), .CELL_W(4), .INIT_FILE(""),
                  .OOB_VALUE(4'hF), .ROM_INIT(ROM_B))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of map A: a countdown of busy edges and a plain array image.
  int   m_left;
  logic m_rom [AD];
  logic m_mem [AD];
  logic e_rdata, e_rvalid, e_n, e_e, e_s, e_w, e_nvalid, e_err;
  int   xi, yi;

  initial begin
    for (int i = 0; i < AD; i++) m_rom[i] = ROM_A[i];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = AD;
      e_rdata = 0; e_rvalid = 0; e_nvalid = 0; e_err = 0;
      e_n = 0; e_e = 0; e_s = 0; e_w = 0;
    end else if (m_left > 0) begin
      e_rvalid = 0;
      e_nvalid = 0;
      e_err    = ifa.rd | ifa.wr | ifa.nbr_rd;
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < AD; i++) m_mem[i] = m_rom[i];
      end
    end else begin
      xi = int'(ifa.x);
      yi = int'(ifa.y);
      e_err    = 0;
      e_rvalid = ifa.rd;
      e_nvalid = ifa.nbr_rd;
      if (ifa.rd) e_rdata = m_mem[xi*AGH + yi];
      if (ifa.nbr_rd) begin
        e_n = (yi == 0)       ? 1'b1 : m_mem[xi*AGH + yi - 1];
        e_s = (yi == AGH - 1) ? 1'b1 : m_mem[xi*AGH + yi + 1];
        e_e = (xi == AGW - 1) ? 1'b1 : m_mem[(xi+1)*AGH + yi];
        e_w = (xi == 0)       ? 1'b1 : m_mem[(xi-1)*AGH + yi];
      end
      if (ifa.wr) m_mem[xi*AGH + yi] = ifa.wdata;
      if (ifa.init_req) m_left = AD;
    end
  end

  // Compare map A against the model after every edge.
  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("m_busy",   32'(ifa.busy),       32'(m_left > 0));
      chk("m_err",    32'(ifa.access_err), 32'(e_err));
      chk("m_rvalid", 32'(ifa.rvalid),     32'(e_rvalid));
      chk("m_rdata",  32'(ifa.rdata),      32'(e_rdata));
      chk("m_nvalid", 32'(ifa.nbr_valid),  32'(e_nvalid));
      chk("m_nbr",    32'({ifa.nbr_n, ifa.nbr_e, ifa.nbr_s, ifa.nbr_w}),
                      32'({e_n, e_e, e_s, e_w}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int na, nb, ne;

  initial begin
    ifa.init_req = 0; ifa.wr = 0; ifa.wdata = 0; ifa.nbr_rd = 0;
    ifa.rd = 1; ifa.x = 3; ifa.y = 5;          // read held from the start
    ifb.init_req = 0; ifb.wr = 0; ifb.wdata = 0; ifb.rd = 0; ifb.nbr_rd = 0;
    ifb.x = 0; ifb.y = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_busy",   32'(ifa.busy), 1);
    chk("rst_rvalid", 32'(ifa.rvalid), 0);
    chk("rst_rdata",  32'(ifa.rdata), 0);
    chk("rst_err",    32'(ifa.access_err), 0);
    chk("rst_nvalid", 32'(ifa.nbr_valid), 0);
    chk("rst_busy_b", 32'(ifb.busy), 1);

    // T1: init length and access errors while busy, then the held read lands.
    rst = 0;
    na = 0; nb = 0; ne = 0;
    for (int i = 0; i < 1000 && (ifa.busy || ifb.busy); i++) begin
      if (ifa.busy) na++;
      if (ifb.busy) nb++;
      @(negedge clk);
      if (ifa.access_err) ne++;
    end
    chk("t1_busy_edges",   32'(na), 256);
    chk("t1_busy_edges_b", 32'(nb), 32);
    chk("t1_err_pulses",   32'(ne), 256);
    @(posedge clk); #1;
    chk("t1_rvalid", 32'(ifa.rvalid), 1);
    chk("t1_rdata",  32'(ifa.rdata), 1);
    chk("t1_err",    32'(ifa.access_err), 0);
    @(negedge clk); ifa.rd = 0;
    @(posedge clk); #1;
    chk("t1_rvalid_fall", 32'(ifa.rvalid), 0);
    chk("t1_rdata_hold",  32'(ifa.rdata), 1);

    // T2: read-first on same-cell read+write.
    @(negedge clk); ifa.x = 7; ifa.y = 7; ifa.wr = 1; ifa.wdata = 1; ifa.rd = 1;
    @(posedge clk); #1;
    chk("t2_old", 32'(ifa.rdata), 0);
    @(negedge clk); ifa.wr = 0;
    @(posedge clk); #1;
    chk("t2_new", 32'(ifa.rdata), 1);
    @(negedge clk); ifa.rd = 0;

    // T3: neighbour fetch at both grid corners.
    ifa.nbr_rd = 1; ifa.x = 0; ifa.y = 0;
    @(posedge clk); #1;
    chk("t3_nvalid", 32'(ifa.nbr_valid), 1);
    chk("t3_00_nesw", 32'({ifa.nbr_n, ifa.nbr_e, ifa.nbr_s, ifa.nbr_w}), 32'b1101);
    @(negedge clk); ifa.x = 15; ifa.y = 15;
    @(posedge clk); #1;
    chk("t3_ff_nesw", 32'({ifa.nbr_n, ifa.nbr_e, ifa.nbr_s, ifa.nbr_w}), 32'b1110);
    @(negedge clk); ifa.nbr_rd = 0;
    @(posedge clk); #1;
    chk("t3_nvalid_fall", 32'(ifa.nbr_valid), 0);

    // T4: init_req restores the ROM image; a second init_req while busy is ignored.
    @(negedge clk); ifa.x = 2; ifa.y = 2; ifa.wr = 1; ifa.wdata = 1;
    @(negedge clk); ifa.wr = 0; ifa.rd = 1;
    @(posedge clk); #1;
    chk("t4_written", 32'(ifa.rdata), 1);
    @(negedge clk); ifa.rd = 0; ifa.init_req = 1;
    @(negedge clk); ifa.init_req = 0;
    na = 0;
    for (int i = 0; i < 1000 && ifa.busy; i++) begin
      na++;
      ifa.init_req = (i == 50);
      @(negedge clk);
    end
    ifa.init_req = 0;
    chk("t4_busy_edges", 32'(na), 256);
    ifa.rd = 1;
    @(posedge clk); #1;
    chk("t4_restored", 32'(ifa.rdata), 0);
    chk("t4_rvalid",   32'(ifa.rvalid), 1);
    @(negedge clk); ifa.rd = 0;

    // T5: async reset during a re-init.
    ifa.x = 1; ifa.y = 0; ifa.wr = 1; ifa.wdata = 0;
    @(negedge clk); ifa.wr = 0; ifa.rd = 1; ifa.x = 3; ifa.y = 5;
    @(posedge clk); #1;
    chk("t5_pre_rdata", 32'(ifa.rdata), 1);
    @(negedge clk); ifa.init_req = 1; ifa.rd = 0;
    @(negedge clk); ifa.init_req = 0; ifa.rd = 1;
    repeat (100) @(posedge clk);
    #3;
    chk("t5_pre_err", 32'(ifa.access_err), 1);
    rst = 1;
    #1;
    chk("t5_async_busy",  32'(ifa.busy), 1);
    chk("t5_async_err",   32'(ifa.access_err), 0);
    chk("t5_async_rdata", 32'(ifa.rdata), 0);
    repeat (3) @(negedge clk);
    rst = 0;
    na = 0;
    for (int i = 0; i < 1000 && ifa.busy; i++) begin
      na++;
      @(negedge clk);
    end
    chk("t5_busy_edges", 32'(na), 256);
    @(posedge clk); #1;
    chk("t5_img_35", 32'(ifa.rdata), 1);
    @(negedge clk); ifa.x = 1; ifa.y = 0;
    @(posedge clk); #1;
    chk("t5_img_10", 32'(ifa.rdata), 1);
    @(negedge clk); ifa.rd = 0;

    // T6: narrow map with 4-bit cells.
    ifb.nbr_rd = 1; ifb.rd = 1; ifb.x = 7; ifb.y = 3;
    @(posedge clk); #1;
    chk("t6_nvalid", 32'(ifb.nbr_valid), 1);
    chk("t6_n", 32'(ifb.nbr_n), 32'h5);
    chk("t6_e", 32'(ifb.nbr_e), 32'hF);
    chk("t6_s", 32'(ifb.nbr_s), 32'hF);
    chk("t6_w", 32'(ifb.nbr_w), 32'hA);
    chk("t6_rdata_73", 32'(ifb.rdata), 0);
    @(negedge clk); ifb.nbr_rd = 0; ifb.y = 2;
    @(posedge clk); #1;
    chk("t6_rdata_72", 32'(ifb.rdata), 32'h5);
    chk("t6_rvalid",   32'(ifb.rvalid), 1);
    @(negedge clk); ifb.rd = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
